// File: rtl/uart_tx.sv
// uart_tx: UART transmit engine. Reads bytes from the TX FIFO (registered
// read, one-cycle latency) and serialises them onto txd, 8N1 by default.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_NUM    = 434,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_WIDTH-1:0] BAUD_LAST = DIV_WIDTH'(DIV_NUM - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  txd_q, txd_d;
  logic                  bit_end;
  logic [DIV_WIDTH-1:0]  baud_nxt;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  // Bit boundary: last cycle of the current bit period.
  assign bit_end  = (baud_q == BAUD_LAST);
  assign baud_nxt = bit_end ? '0 : baud_q + 1'b1;

  // Outputs decoded from registered state; txd is a flop so the pin lags by one cycle.
  assign fifo_r_en = (state_q == FETCH);
  assign busy      = (state_q != IDLE);
  assign tx_done   = (state_q == STOP) && bit_end;
  assign txd       = txd_q;

  // State and datapath registers; reset forces the line high and drops any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, baud/bit counting and next line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = '0;
    bit_d   = bit_q;
    txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_r_data;
`ifdef UART_TX_PARITY_EN
        par_d   = ^fifo_r_data;
`endif
        state_d = START;
      end
      START: begin
        txd_d  = 1'b0;
        baud_d = baud_nxt;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        txd_d  = shift_q[0];
        baud_d = baud_nxt;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d  = par_q;
        baud_d = baud_nxt;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        txd_d  = 1'b1;
        baud_d = baud_nxt;
        // Only place besides IDLE where the FIFO flag is looked at.
        if (bit_end) state_d = fifo_empty ? IDLE : FETCH;
      end
      default: begin
        state_d = IDLE;
        bit_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random-stimulus bench for uart_tx with a FIFO model and a
// line-level receiver reference (frame built from the byte, checked per cycle).
module tb_uart_tx;
  localparam int DW = 8;
  localparam int D  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  localparam int L = NB * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_r_en;
  logic [7:0] fifo_r_data = 8'h00;
  logic       txd, busy, tx_done;

  logic       f2_empty = 1'b1;
  logic       f2_ren;
  logic [7:0] f2_rdata = 8'h00;
  logic       txd2, busy2, done2;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .DIV_NUM(D), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .fifo_r_data(fifo_r_data), .txd(txd), .busy(busy), .tx_done(tx_done));

  uart_tx #(.DATA_WIDTH(DW), .DIV_NUM(1), .DIV_WIDTH(16)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(f2_empty), .fifo_r_en(f2_ren),
    .fifo_r_data(f2_rdata), .txd(txd2), .busy(busy2), .tx_done(done2));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected line bits, index 0 = start bit, sent in index order.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int  reads = 0, frames_done = 0, last_gap = 0;
  bit  mon_en = 1'b0;

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (frames_done < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("frames_timeout", 32'(frames_done >= target), 1);
  endtask

  // FIFO model: registered read, data presented the cycle after the strobe.
  initial begin
    logic [7:0] pend;
    bit ren_prev;
    pend = 8'h00;
    ren_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ren_prev = 1'b0;
        continue;
      end
      if (ren_prev) fifo_r_data = pend;
      else          fifo_r_data = 8'($urandom);
      ren_prev = fifo_r_en;
      if (fifo_r_en) begin
        chk("no_underflow", 32'(fq.size() > 0), 1);
        pend = (fq.size() > 0) ? fq.pop_front() : 8'h00;
        exp_q.push_back(pend);
        reads++;
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  // Line receiver: every cycle of every frame is compared against the byte read.
  initial begin
    logic [NB-1:0] fb;
    int   fi, hi_run;
    bit   in_frame;
    logic prev;
    fb = '0; fi = 0; hi_run = 0; in_frame = 1'b0; prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        in_frame = 1'b0; prev = 1'b1; hi_run = 0;
        continue;
      end
      if (!in_frame) begin
        if (prev === 1'b1 && txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("frame_without_read", 0, 1);
            fb = frame_bits(8'h00);
          end else begin
            fb = frame_bits(exp_q.pop_front());
          end
          last_gap = D + hi_run;
          fi = 0;
          in_frame = 1'b1;
        end else begin
          chk("done_idle", 32'(tx_done), 0);
          if (txd === 1'b1) hi_run++;
        end
      end
      if (in_frame) begin
        chk("txd_bit", 32'(txd), 32'(fb[fi/D]));
        chk("tx_done", 32'(tx_done), 32'(fi == L - 2));
        if (fi <= L - 2) chk("busy_frame", 32'(busy), 1);
        fi++;
        if (fi == L) begin
          in_frame = 1'b0;
          frames_done++;
          hi_run = 0;
        end
      end
      prev = txd;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r0, f0, nb, lows, dn;
    bit seen;
    logic [NB-1:0] fb2;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ren", 32'(fifo_r_en), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_txd_d1", 32'(txd2), 1);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // empty hold
    repeat (1000) begin
      @(negedge clk);
      chk("hold_ren", 32'(fifo_r_en), 0);
      chk("hold_txd", 32'(txd), 1);
      chk("hold_busy", 32'(busy), 0);
    end

    // single byte, latency from fifo_empty falling to start bit
    r0 = reads; f0 = frames_done;
    push(8'hA5);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (txd !== 1'b0 && k < 20);
    chk("latency", 32'(k), 4);
    wait_frames(f0 + 1, 4 * L);
    repeat (2) @(negedge clk);
    chk("single_reads", 32'(reads - r0), 1);
    chk("single_busy_end", 32'(busy), 0);

    // back-to-back frames
    r0 = reads; f0 = frames_done;
    push(8'h00);
    push(8'hFF);
    lows = 0; dn = 0; seen = 1'b0; k = 0;
    while (dn < 2 && k < 6 * L) begin
      @(negedge clk);
      k++;
      if (busy) seen = 1'b1;
      else if (seen) lows++;
      if (tx_done) dn++;
    end
    chk("b2b_done_pulses", 32'(dn), 2);
    chk("b2b_busy_drops", 32'(lows), 0);
    wait_frames(f0 + 2, 4 * L);
    chk("b2b_gap", 32'(last_gap), 32'(D + 2));
    chk("b2b_reads", 32'(reads - r0), 2);

`ifdef UART_TX_PARITY_EN
    // parity frames: 07 -> 1, 03 -> 0 (checked by the receiver model)
    f0 = frames_done;
    push(8'h07);
    push(8'h03);
    wait_frames(f0 + 2, 6 * L);
`endif

    // random bursts with random idle gaps
    r0 = reads; f0 = frames_done; nb = 0;
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3 * L)) @(negedge clk);
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) push(8'($urandom));
      nb += k;
    end
    wait_frames(f0 + nb, nb * (L + 4) + 100);
    repeat (2) @(negedge clk);
    chk("rand_reads", 32'(reads - r0), 32'(nb));
    chk("rand_busy_end", 32'(busy), 0);

    // reset in the middle of the data bits
    push(8'h5A);
    k = 0;
    while (txd !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (3 * D) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ren", 32'(fifo_r_en), 0);
    chk("midrst_done", 32'(tx_done), 0);
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = reads;
    repeat (50) begin
      @(negedge clk);
      chk("post_rst_txd", 32'(txd), 1);
      chk("post_rst_busy", 32'(busy), 0);
    end
    chk("post_rst_reads", 32'(reads - r0), 0);

    // DIV_NUM=1 instance: 8'h81, one cycle per bit
    f2_empty = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (f2_ren !== 1'b1 && k < 10);
    chk("d1_ren", 32'(f2_ren), 1);
    f2_empty = 1'b1;
    @(negedge clk);
    f2_rdata = 8'h81;
    fb2 = frame_bits(8'h81);
    k = 0;
    while (txd2 !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < NB; i++) begin
      chk("d1_txd", 32'(txd2), 32'(fb2[i]));
      chk("d1_done", 32'(done2), 32'(i == NB - 2));
      chk("d1_ren_once", 32'(f2_ren), 0);
      if (i <= NB - 2) chk("d1_busy", 32'(busy2), 1);
      @(negedge clk);
    end
    @(negedge clk);
    chk("d1_busy_end", 32'(busy2), 0);
    chk("d1_idle_txd", 32'(txd2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
